// File: rtl/arya_ctrl_pkg.sv
// rtl/arya_ctrl_pkg.sv - issue controller state encoding, widths and write-back entry type
package arya_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  localparam int STALL_CNT_WIDTH   = 16;
  // Entries carry the widest supported register address; narrower files zero-extend.
  localparam int WB_ADDR_MAX_WIDTH = 8;

  typedef struct packed {
    logic                         valid;
    logic [WB_ADDR_MAX_WIDTH-1:0] addr;
  } wb_entry_t;

  function automatic logic [STALL_CNT_WIDTH-1:0] sat_inc(input logic [STALL_CNT_WIDTH-1:0] v);
    return (&v) ? v : v + STALL_CNT_WIDTH'(1);
  endfunction

endpackage

// File: rtl/wb_delay_line.sv
// rtl/wb_delay_line.sv - fixed-latency shift register of {valid, addr} feeding the regfile write strobe
module wb_delay_line
  import arya_ctrl_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_push_valid,
  input  logic [ADDR_W-1:0] i_push_addr,
  output logic              o_wb_en,
  output logic [ADDR_W-1:0] o_wb_addr,
  output logic              o_empty
);

  wb_entry_t r_stage [DEPTH];
  wb_entry_t w_push;
  logic      w_unused_addr_hi;

  always_comb begin
    w_push       = '0;
    w_push.valid = i_push_valid;
    w_push.addr  = WB_ADDR_MAX_WIDTH'(i_push_addr);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_stage[i] <= '0;
      end
    end else begin
      r_stage[0] <= w_push;
      for (int i = 1; i < DEPTH; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  // The last stage is the registered write-back output.
  assign o_wb_en          = r_stage[DEPTH-1].valid;
  assign o_wb_addr        = r_stage[DEPTH-1].addr[ADDR_W-1:0];
  assign w_unused_addr_hi = ^r_stage[DEPTH-1].addr;

  always_comb begin
    o_empty = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_stage[i].valid) begin
        o_empty = 1'b0;
      end
    end
  end

endmodule

// File: rtl/issue_scoreboard.sv
// rtl/issue_scoreboard.sv - RAW/WAW issue scoreboard with delayed write-back and drain/halt
// Optional ISSUE_BYPASS_EN: write-back-cycle bypass with fwd_r1_out/fwd_r2_out.
module issue_scoreboard
  import arya_ctrl_pkg::*;
#(
  parameter int  REGFILE_ADDR_WIDTH = 5,
  parameter int  INST_ADDR_WIDTH    = 9,
  parameter int  WB_LATENCY         = 3,
  localparam int NUM_REGS           = 2 ** REGFILE_ADDR_WIDTH
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          dec_valid_in,
  input  logic [REGFILE_ADDR_WIDTH-1:0] R1_addr_in,
  input  logic [REGFILE_ADDR_WIDTH-1:0] R2_addr_in,
  input  logic [REGFILE_ADDR_WIDTH-1:0] WR_addr_in,
  input  logic                          WR_en_in,
  input  logic                          imm_sel_in,
  input  logic [INST_ADDR_WIDTH-1:0]    pc_in,
  input  logic                          drain_in,
  output logic                          issue_out,
  output logic                          stall_out,
  output logic [INST_ADDR_WIDTH-1:0]    pc_hold_out,
  output logic                          wb_en_out,
  output logic [REGFILE_ADDR_WIDTH-1:0] wb_addr_out,
  output logic [NUM_REGS-1:0]           busy_vec_out,
  output logic                          drained_out,
`ifdef ISSUE_BYPASS_EN
  output logic                          fwd_r1_out,
  output logic                          fwd_r2_out,
`endif
  output logic [STALL_CNT_WIDTH-1:0]    stall_cnt_out
);

  state_t                      r_state;
  logic                        r_drained;
  logic [NUM_REGS-1:0]         r_busy;
  logic [INST_ADDR_WIDTH-1:0]  r_pc_hold;
  logic [STALL_CNT_WIDTH-1:0]  r_stall_cnt;

  logic                          w_wb_en;
  logic [REGFILE_ADDR_WIDTH-1:0] w_wb_addr;
  logic                          w_dl_empty;
  logic [NUM_REGS-1:0]           w_busy_eff;
  logic [NUM_REGS-1:0]           w_set;
  logic [NUM_REGS-1:0]           w_clr;
  logic                          w_haz;
  logic                          w_issue;
  logic                          w_stall;
  logic                          w_push_valid;
  logic                          w_quiet;

  wb_delay_line #(
    .ADDR_W (REGFILE_ADDR_WIDTH),
    .DEPTH  (WB_LATENCY)
  ) u_wb_delay (
    .clk          (clk),
    .reset        (reset),
    .i_push_valid (w_push_valid),
    .i_push_addr  (WR_addr_in),
    .o_wb_en      (w_wb_en),
    .o_wb_addr    (w_wb_addr),
    .o_empty      (w_dl_empty)
  );

  assign w_clr = NUM_REGS'(w_wb_en) << w_wb_addr;
  assign w_set = NUM_REGS'(w_push_valid) << WR_addr_in;

`ifdef ISSUE_BYPASS_EN
  // The register being written back this cycle is readable from the write-back bus.
  assign w_busy_eff = r_busy & ~w_clr;
  assign fwd_r1_out = w_issue & w_wb_en & (w_wb_addr == R1_addr_in);
  assign fwd_r2_out = w_issue & w_wb_en & ~imm_sel_in & (w_wb_addr == R2_addr_in);
`else
  assign w_busy_eff = r_busy;
`endif

  assign w_haz = w_busy_eff[R1_addr_in]
               | (~imm_sel_in & w_busy_eff[R2_addr_in])
               | (WR_en_in & w_busy_eff[WR_addr_in]);

  // A raised drain blocks issue in the same cycle, before the state has moved.
  assign w_issue      = ~reset & dec_valid_in & (r_state == ST_RUN) & ~drain_in & ~w_haz;
  assign w_stall      = ~reset & dec_valid_in & ~w_issue;
  assign w_push_valid = w_issue & WR_en_in;
  assign w_quiet      = w_dl_empty & (r_busy == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_RUN;
      r_drained <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (drain_in) begin
            r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (!drain_in) begin
            r_state <= ST_RUN;
          end else if (w_quiet) begin
            r_state   <= ST_HALTED;
            r_drained <= 1'b1;
          end
        end
        ST_HALTED: begin
          if (!drain_in) begin
            r_state   <= ST_RUN;
            r_drained <= 1'b0;
          end
        end
        default: begin
          r_state   <= ST_RUN;
          r_drained <= 1'b0;
        end
      endcase
    end
  end

  // Set after clear so a same-cycle re-issue to the retiring register stays busy.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy      <= '0;
      r_pc_hold   <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_busy <= (r_busy & ~w_clr) | w_set;
      if (!w_stall) begin
        r_pc_hold <= pc_in;
      end
      if (w_stall) begin
        r_stall_cnt <= sat_inc(r_stall_cnt);
      end
    end
  end

  assign issue_out     = w_issue;
  assign stall_out     = w_stall;
  assign pc_hold_out   = r_pc_hold;
  assign wb_en_out     = w_wb_en;
  assign wb_addr_out   = w_wb_addr;
  assign busy_vec_out  = r_busy;
  assign drained_out   = r_drained;
  assign stall_cnt_out = r_stall_cnt;

endmodule

// File: tb/tb_issue_scoreboard.sv
// tb/tb_issue_scoreboard.sv - scoreboard bench for issue_scoreboard against a time-based model
module tb_issue_scoreboard;

  localparam int L = 3;

  logic        clk = 1'b0;
  logic        reset, dec_valid_in, WR_en_in, imm_sel_in, drain_in;
  logic [4:0]  R1_addr_in, R2_addr_in, WR_addr_in;
  logic [8:0]  pc_in;
  logic        issue_out, stall_out, wb_en_out, drained_out;
  logic [8:0]  pc_hold_out;
  logic [4:0]  wb_addr_out;
  logic [31:0] busy_vec_out;
  logic [15:0] stall_cnt_out;
`ifdef ISSUE_BYPASS_EN
  logic        fwd_r1_out, fwd_r2_out;
`endif

  always #5 clk = ~clk;

  issue_scoreboard #(.REGFILE_ADDR_WIDTH(5), .INST_ADDR_WIDTH(9), .WB_LATENCY(L)) dut (
    .clk(clk), .reset(reset), .dec_valid_in(dec_valid_in),
    .R1_addr_in(R1_addr_in), .R2_addr_in(R2_addr_in), .WR_addr_in(WR_addr_in),
    .WR_en_in(WR_en_in), .imm_sel_in(imm_sel_in), .pc_in(pc_in), .drain_in(drain_in),
    .issue_out(issue_out), .stall_out(stall_out), .pc_hold_out(pc_hold_out),
    .wb_en_out(wb_en_out), .wb_addr_out(wb_addr_out), .busy_vec_out(busy_vec_out),
    .drained_out(drained_out),
`ifdef ISSUE_BYPASS_EN
    .fwd_r1_out(fwd_r1_out), .fwd_r2_out(fwd_r2_out),
`endif
    .stall_cnt_out(stall_cnt_out)
  );

  typedef struct {
    logic        issue, stall, wb_en, drained, fwd1, fwd2;
    logic [4:0]  wb_addr;
    logic [31:0] busy;
    logic [15:0] scnt;
    logic [8:0]  pch;
  } exp_t;

  typedef struct {
    logic [4:0] addr;
    int         t_iss;
  } wr_t;

  exp_t       q[$];
  wr_t        pend[$];
  int         mode = 0;
  int         t = 0;
  int         scnt = 0;
  logic [8:0] pch = '0;
  logic [8:0] pcv = '0;
  int         n_vec = 0;
  int         n_err = 0;

  // Model: a write issued at cycle s makes its register busy over (s, s+L] and strobes at s+L.
  task automatic apply(input bit rst, input bit dv, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [4:0] wr, input bit wen, input bit imm, input logic [8:0] pc,
                       input bit drn, output bit stalled);
    exp_t        e;
    logic [31:0] busy, eff;
    bit          haz;
    wr_t         keep[$];
    @(posedge clk);
    #1;
    reset = rst; dec_valid_in = dv; R1_addr_in = r1; R2_addr_in = r2; WR_addr_in = wr;
    WR_en_in = wen; imm_sel_in = imm; pc_in = pc; drain_in = drn;
    busy = '0; eff = '0; e.wb_en = 1'b0; e.wb_addr = '0;
    foreach (pend[i]) begin
      busy[pend[i].addr] = 1'b1;
      if (pend[i].t_iss + L == t) begin
        e.wb_en = 1'b1;
        e.wb_addr = pend[i].addr;
      end
`ifdef ISSUE_BYPASS_EN
      if (pend[i].t_iss + L != t) eff[pend[i].addr] = 1'b1;
`else
      eff[pend[i].addr] = 1'b1;
`endif
    end
    haz = eff[r1] | (!imm & eff[r2]) | (wen & eff[wr]);
    e.issue   = !rst && dv && mode == 0 && !drn && !haz;
    e.stall   = !rst && dv && !e.issue;
    e.busy    = busy;
    e.drained = (mode == 2);
    e.scnt    = 16'(scnt);
    e.pch     = pch;
    e.fwd1    = e.issue && e.wb_en && e.wb_addr == r1;
    e.fwd2    = e.issue && e.wb_en && !imm && e.wb_addr == r2;
    q.push_back(e);
    stalled = e.stall;
    if (rst) begin
      pend.delete();
      mode = 0; scnt = 0; pch = '0;
    end else begin
      if (e.issue && wen) pend.push_back('{wr, t});
      if (e.stall && scnt < 65535) scnt++;
      if (!e.stall) pch = pc;
      case (mode)
        0: if (drn) mode = 1;
        1: if (!drn) mode = 0; else if (busy == 0) mode = 2;
        default: if (!drn) mode = 0;
      endcase
    end
    foreach (pend[i]) if (pend[i].t_iss + L > t) keep.push_back(pend[i]);
    pend = keep;
    t++;
  endtask

  task automatic idle(input int n);
    bit st;
    for (int k = 0; k < n; k++) apply(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, pcv, 1'b0, st);
  endtask

  // Present one instruction, re-presenting it while stalled for at most maxc cycles.
  task automatic instr(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] wr,
                       input bit wen, input bit imm, input bit drn, input int maxc);
    bit st;
    for (int k = 0; k < maxc; k++) begin
      apply(1'b0, 1'b1, r1, r2, wr, wen, imm, pcv, drn, st);
      if (!st) begin
        pcv = pcv + 9'd1;
        break;
      end
    end
  endtask

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s vector %0d: got %h expected %h", nm, n_vec, act, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        e = q.pop_front();
        n_vec++;
        cmp("issue_out", 32'(issue_out), 32'(e.issue));
        cmp("stall_out", 32'(stall_out), 32'(e.stall));
        cmp("wb_en_out", 32'(wb_en_out), 32'(e.wb_en));
        if (e.wb_en) cmp("wb_addr_out", 32'(wb_addr_out), 32'(e.wb_addr));
        cmp("busy_vec_out", busy_vec_out, e.busy);
        cmp("drained_out", 32'(drained_out), 32'(e.drained));
        cmp("stall_cnt_out", 32'(stall_cnt_out), 32'(e.scnt));
        cmp("pc_hold_out", 32'(pc_hold_out), 32'(e.pch));
`ifdef ISSUE_BYPASS_EN
        cmp("fwd_r1_out", 32'(fwd_r1_out), 32'(e.fwd1));
        cmp("fwd_r2_out", 32'(fwd_r2_out), 32'(e.fwd2));
`endif
      end
    end
  end

  initial begin : stimulus
    bit         st, drn, dv, wen, imm, rst;
    logic [4:0] r1, r2, wr;
    logic [8:0] pc;
    st = 1'b0; drn = 1'b0; dv = 1'b0; wen = 1'b0; imm = 1'b0; rst = 1'b0;
    r1 = '0; r2 = '0; wr = '0; pc = '0;
    reset = 1'b1; dec_valid_in = 1'b0; R1_addr_in = '0; R2_addr_in = '0; WR_addr_in = '0;
    WR_en_in = 1'b0; imm_sel_in = 1'b0; pc_in = '0; drain_in = 1'b0;
    repeat (2) @(posedge clk);

    idle(2);
    instr(5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0, 1); idle(5);
    instr(5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0, 1);
    instr(5'd3, 5'd2, 5'd4, 1'b1, 1'b0, 1'b0, 10); idle(5);
    instr(5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0, 1);
    instr(5'd1, 5'd3, 5'd7, 1'b1, 1'b1, 1'b0, 1);
    instr(5'd1, 5'd3, 5'd8, 1'b1, 1'b0, 1'b0, 10); idle(5);
    instr(5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1);
    instr(5'd0, 5'd0, 5'd6, 1'b1, 1'b0, 1'b0, 1);
    instr(5'd1, 5'd2, 5'd9, 1'b1, 1'b0, 1'b1, 10);
    instr(5'd1, 5'd2, 5'd9, 1'b1, 1'b0, 1'b0, 3); idle(4);
    instr(5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1);
    instr(5'd1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b0, 10); idle(5);
    instr(5'd0, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0, 1);
    instr(5'd1, 5'd1, 5'd3, 1'b0, 1'b0, 1'b0, 1);
    instr(5'd3, 5'd1, 5'd3, 1'b0, 1'b0, 1'b0, 10); idle(5);
    instr(5'd0, 5'd0, 5'd1, 1'b1, 1'b0, 1'b0, 1);
    instr(5'd0, 5'd0, 5'd2, 1'b1, 1'b0, 1'b0, 1);
    apply(1'b1, 1'b1, 5'd1, 5'd2, 5'd4, 1'b1, 1'b0, pcv, 1'b0, st);
    idle(6);

    st = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (!st) begin
        dv  = ($urandom % 10) < 8;
        r1  = ($urandom % 6 == 0) ? 5'($urandom) : 5'($urandom % 8);
        r2  = 5'($urandom % 8);
        wr  = ($urandom % 6 == 0) ? 5'($urandom) : 5'($urandom % 8);
        wen = ($urandom % 4) != 0;
        imm = ($urandom % 4) == 0;
        pc  = 9'($urandom);
      end
      if (drn) drn = ($urandom % 8) != 0;
      else     drn = ($urandom % 40) == 0;
      rst = ($urandom % 300) == 0;
      apply(rst, dv, r1, r2, wr, wen, imm, pc, drn, st);
    end

    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain_queue: got %0d pending expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
